// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: valid bit, hold, bubble insertion, exception clear, Tnew countdown, perf counters.
// One-cycle latency, no in->out combinational path; stall holds the stage, flush/clear overwrite it with a bubble.
module pipe_stage_reg #(
    parameter int          DATA_W           = 32,
    parameter int          N_DATA           = 4,
    parameter int          WA_W             = 5,
    parameter int          TNEW_W           = 2,
    parameter int          EXC_W            = 5,
    parameter int          DEC_TNEW         = 1,
    parameter int          KEEP_PC_ON_FLUSH = 1,
    parameter logic [31:0] CLR_PC           = 32'h0000_4180,
    parameter int          CNT_W            = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [WA_W-1:0]          in_wa,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic [EXC_W-1:0]         in_exc,
    input  logic                     in_bd,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [WA_W-1:0]          out_wa,
    output logic [TNEW_W-1:0]        out_tnew,
    output logic [EXC_W-1:0]         out_exc,
    output logic                     out_bd,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [TNEW_W-1:0] tnew_nxt;
    logic [WA_W-1:0]   wa_nxt;

    // An empty slot must look like "no pending write" to the hazard unit.
    always_comb begin
        tnew_nxt = in_tnew;
        wa_nxt   = in_wa;
        if ((DEC_TNEW != 0) && (in_tnew != '0)) begin
            tnew_nxt = in_tnew - TNEW_ONE;
        end
        if (!in_valid) begin
            tnew_nxt = '0;
            wa_nxt   = '0;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
            out_data   <= '0;
            out_wa     <= '0;
            out_tnew   <= '0;
            out_exc    <= '0;
            out_bd     <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (clear || flush) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_data   <= '0;
            out_wa     <= '0;
            out_tnew   <= '0;
            out_exc    <= '0;
            bubble_cnt <= sat_inc(bubble_cnt);
            if (clear) begin
                out_pc <= CLR_PC;
                out_bd <= 1'b0;
            end else begin
                // Flushed slot may keep its pc/bd so a later exception still reports the right EPC.
                out_pc <= (KEEP_PC_ON_FLUSH != 0) ? in_pc : '0;
                out_bd <= (KEEP_PC_ON_FLUSH != 0) ? in_bd : 1'b0;
            end
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end else begin
            out_valid <= in_valid;
            out_instr <= in_instr;
            out_pc    <= in_pc;
            out_data  <= in_data;
            out_wa    <= wa_nxt;
            out_tnew  <= tnew_nxt;
            out_exc   <= in_exc;
            out_bd    <= in_bd;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a per-edge behavioural model (CNT_W=4).
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         stall = 1'b0, flush = 1'b0, clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_instr = '0, in_pc = '0;
    logic [127:0] in_data = '0;
    logic [4:0]   in_wa = '0;
    logic [1:0]   in_tnew = '0;
    logic [4:0]   in_exc = '0;
    logic         in_bd = 1'b0;
    logic         out_valid, out_bd;
    logic [31:0]  out_instr, out_pc;
    logic [127:0] out_data;
    logic [4:0]   out_wa, out_exc;
    logic [1:0]   out_tnew;
    logic [3:0]   stall_cnt, bubble_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Expected stage contents
    logic         m_valid, m_bd;
    logic [31:0]  m_instr, m_pc;
    logic [127:0] m_data;
    logic [4:0]   m_wa, m_exc;
    int           m_tnew, m_sc, m_bc;

    pipe_stage_reg #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clear(clear),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .in_wa(in_wa), .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
        .out_wa(out_wa), .out_tnew(out_tnew), .out_exc(out_exc), .out_bd(out_bd),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/valid"}, 128'(out_valid), 128'(m_valid));
        check({tag, "/instr"}, 128'(out_instr), 128'(m_instr));
        check({tag, "/pc"}, 128'(out_pc), 128'(m_pc));
        check({tag, "/data"}, out_data, m_data);
        check({tag, "/wa"}, 128'(out_wa), 128'(m_wa));
        check({tag, "/tnew"}, 128'(out_tnew), 128'(m_tnew));
        check({tag, "/exc"}, 128'(out_exc), 128'(m_exc));
        check({tag, "/bd"}, 128'(out_bd), 128'(m_bd));
        check({tag, "/stall_cnt"}, 128'(stall_cnt), 128'(m_sc));
        check({tag, "/bubble_cnt"}, 128'(bubble_cnt), 128'(m_bc));
    endtask

    task automatic model_zero();
        m_valid = 0; m_instr = 0; m_pc = 0; m_data = 0; m_wa = 0;
        m_tnew = 0; m_exc = 0; m_bd = 0; m_sc = 0; m_bc = 0;
    endtask

    task automatic bubble(input logic [31:0] pc, input logic bd);
        m_valid = 0; m_instr = 0; m_data = 0; m_wa = 0; m_tnew = 0; m_exc = 0;
        m_pc = pc; m_bd = bd;
        m_bc = (m_bc < 15) ? m_bc + 1 : 15;
    endtask

    // One clock edge: model follows the stage rules, then outputs are compared at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset) model_zero();
        else if (clear) bubble(32'h0000_4180, 1'b0);
        else if (flush) bubble(in_pc, in_bd);
        else if (stall) m_sc = (m_sc < 15) ? m_sc + 1 : 15;
        else begin
            m_valid = in_valid; m_instr = in_instr; m_pc = in_pc; m_data = in_data;
            m_exc = in_exc; m_bd = in_bd;
            m_wa = in_valid ? in_wa : 5'd0;
            m_tnew = !in_valid ? 0 : (in_tnew > 0 ? int'(in_tnew) - 1 : 0);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [127:0] d,
                         input logic [4:0] wa, input logic [1:0] tn, input logic bd);
        in_valid = v; in_pc = pc; in_data = d; in_wa = wa; in_tnew = tn; in_bd = bd;
        in_instr = $urandom; in_exc = 5'($urandom_range(0, 31));
    endtask

    task automatic ctl(input logic s, input logic f, input logic c);
        stall = s; flush = f; clear = c;
    endtask

    initial begin
        model_zero();
        #2 check_all("reset_init");
        @(negedge clk) reset = 1'b1;

        // Load a valid slot, then assert reset mid-cycle: outputs must drop before any edge.
        drive(1, 32'h0000_1234, 128'hABCD, 5'd9, 2'd3, 1);
        tick("pre_reset");
        #2 reset = 1'b0;
        #1 model_zero();
        check_all("async_reset");
        @(negedge clk) reset = 1'b1;
        drive(1, 32'h0000_3000, 128'h1, 5'd1, 2'd1, 0);
        tick("first_load");
        check("first_pc", 128'(out_pc), 128'h3000);

        // Tnew countdown and invalid-slot write address masking
        drive(1, 32'h0000_3004, 128'h2, 5'd5, 2'd2, 0);
        tick("tnew2");
        check("tnew2_val", 128'(out_tnew), 128'd1);
        check("wa5_val", 128'(out_wa), 128'd5);
        drive(1, 32'h0000_3008, 128'h3, 5'd6, 2'd0, 0);
        tick("tnew0");
        check("tnew0_nowrap", 128'(out_tnew), 128'd0);
        drive(0, 32'h0000_300C, 128'h4, 5'd7, 2'd3, 0);
        tick("invalid");
        check("invalid_wa", 128'(out_wa), 128'd0);

        // Stall holds everything while inputs change
        drive(1, 32'h0000_3004, 128'hDEADBEEF, 5'd3, 2'd3, 0);
        tick("stall_load");
        ctl(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, {4{$urandom}}, 5'($urandom), 2'($urandom), 1'($urandom));
            tick("stall_hold");
        end
        check("stall_pc", 128'(out_pc), 128'h3004);
        check("stall_data", out_data, 128'hDEADBEEF);
        check("stall_tnew", 128'(out_tnew), 128'd2);
        check("stall_cnt3", 128'(stall_cnt), 128'd3);

        // Flush overrides stall and keeps pc/bd
        ctl(1, 1, 0);
        drive(1, 32'h0000_3008, 128'h55, 5'd8, 2'd2, 1);
        tick("flush_stall");
        check("flush_pc", 128'(out_pc), 128'h3008);
        check("flush_bd", 128'(out_bd), 128'd1);
        check("flush_bc", 128'(bubble_cnt), 128'd1);
        check("flush_sc", 128'(stall_cnt), 128'd3);

        // Clear beats flush
        ctl(0, 1, 1);
        tick("clear_flush");
        check("clear_pc", 128'(out_pc), 128'h4180);
        check("clear_bd", 128'(out_bd), 128'd0);

        // Stall counter saturation
        ctl(1, 0, 0);
        for (int i = 0; i < 20; i++) tick("sat");
        check("stall_sat", 128'(stall_cnt), 128'd15);
        ctl(0, 0, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom},
                  5'($urandom), 2'($urandom), 1'($urandom));
            ctl($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 4);
            reset = ($urandom_range(0, 99) >= 3);
            tick("rand");
        end
        reset = 1'b1;
        ctl(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
